// File: rtl/seq_det_prog.sv
// Run-time programmable serial bit-pattern detector with a registered one-cycle det pulse.
// Optional saturating match counter is enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 16,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_valid,
    input  logic               data_in,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               det,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    // The oldest history bit can never fall inside a MAX_LEN window that
    // includes the current bit, so only MAX_LEN-1 bits are stored.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_det;

    logic               w_accept;
    logic [MAX_LEN-1:0] w_win;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_fill_ok;
    logic               w_match;
    logic [LEN_W-1:0]   w_cfg_len;
    logic [LEN_W-1:0]   w_fill_nxt;

    assign w_accept   = data_valid & ~cfg_we;
    assign w_win      = {r_hist, data_in};
    assign w_fill_inc = {1'b0, r_fill} + (LEN_W + 1)'(1);
    assign w_fill_ok  = (w_fill_inc >= {1'b0, r_len});
    assign w_cfg_len  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign w_fill_nxt = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_accept && (r_len != '0) && w_fill_ok &&
                     (((w_win ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat  <= RST_PATTERN;
            r_len  <= LEN_W'(RST_LEN);
            r_ovl  <= RST_OVERLAP;
            r_hist <= '0;
            r_fill <= '0;
            r_det  <= 1'b0;
        end else if (cfg_we) begin
            r_pat  <= cfg_pattern;
            r_len  <= w_cfg_len;
            r_ovl  <= cfg_overlap;
            r_hist <= '0;
            r_fill <= '0;
            r_det  <= 1'b0;
        end else if (data_valid) begin
            r_det <= w_match;
            if (w_match && !r_ovl) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_win[MAX_LEN-2:0];
                r_fill <= w_fill_nxt;
            end
        end else begin
            r_det <= 1'b0;
        end
    end

    assign det = r_det;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Clear wins over a coincident match; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the detection rules.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               rst;
    logic               data_valid;
    logic               data_in;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               det;
    logic [CNT_W-1:0]   match_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int hits     = 0;

    seq_det_prog #(
        .MAX_LEN    (MAX_LEN),
        .RST_PATTERN(8'b0000_1011),
        .RST_LEN    (4),
        .RST_OVERLAP(1'b1),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .det        (det),
        .match_cnt  (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the accepted bits since the last clear, oldest first.
    bit         m_bits[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    bit         m_det;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_match(input bit d);
        bit cand[$];
        if (m_len == 0 || (m_bits.size() + 1) < m_len) return 1'b0;
        cand = m_bits;
        cand.push_back(d);
        // The k-th most recent bit must equal pattern bit k.
        for (int k = 0; k < m_len; k++) begin
            if (cand[cand.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_pat = 8'b0000_1011;
        m_len = 4;
        m_ovl = 1'b1;
        m_cnt = 0;
        m_det = 1'b0;
    endtask

    // Apply the current inputs for one clock and compare outputs after the edge.
    task automatic step(input bit dv, input bit d);
        bit mt;
        data_valid = dv;
        data_in    = d;
        mt = 1'b0;
        if (cfg_we) begin
            m_pat = cfg_pattern;
            m_len = (int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len);
            m_ovl = cfg_overlap;
            m_bits.delete();
            m_det = 1'b0;
        end else if (dv) begin
            mt    = model_match(d);
            m_det = mt;
            if (mt && !m_ovl) begin
                m_bits.delete();
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            end
        end else begin
            m_det = 1'b0;
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        if (cnt_clr) m_cnt = 0;
        else if (mt && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
        @(posedge clk);
        #1;
        if (det === 1'b1) hits++;
        check("det", 32'(det), 32'(m_det));
        check("cnt", 32'(match_cnt), 32'(m_cnt));
    endtask

    task automatic configure(input logic [7:0] pat, input int len, input bit ovl);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cfg_we      = 1'b1;
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cfg_we      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #2;
        check("rst_det_async", 32'(det), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_det", 32'(det), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
    endtask

    task automatic stream(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
    endtask

    initial begin
        rst = 1'b0; data_valid = 1'b0; data_in = 1'b0; cfg_we = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Defaults, overlapping: 1011011 matches after bits 4 and 7.
        hits = 0;
        stream(32'b1011011, 7);
        check("tp1_hits", 32'(hits), 32'd2);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("tp1_cnt", 32'(match_cnt), 32'd2);
`endif

        // Non-overlapping: only the first match counts.
        configure(8'b1011, 4, 1'b0);
        hits = 0;
        stream(32'b1011011, 7);
        check("tp2_hits", 32'(hits), 32'd1);

        // Six-bit pattern, then disabled with len 0.
        configure(8'b110011, 6, 1'b1);
        hits = 0;
        stream(32'b0110011, 7);
        check("tp3_hits", 32'(hits), 32'd1);
        configure(8'b110011, 0, 1'b1);
        hits = 0;
        stream(32'b0110011, 7);
        check("tp3_len0_hits", 32'(hits), 32'd0);

        // Bubbles between bits 2 and 3 neither break the match nor pulse det.
        do_reset();
        hits = 0;
        step(1'b1, 1'b1); step(1'b1, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        check("tp4_bubble_hits", 32'(hits), 32'd0);
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        check("tp4_det", 32'(det), 32'd1);

        // Reset mid-stream discards the partial match.
        hits = 0;
        stream(32'b101, 3);
        do_reset();
        step(1'b1, 1'b1);
        check("tp5_after_rst", 32'(hits), 32'd0);
        stream(32'b011, 3);
        check("tp5_det", 32'(det), 32'd1);

        // Oversized length is clamped; len 1 counter saturation and clear priority.
        configure(8'b1010_1010, 15, 1'b1);
        hits = 0;
        stream(32'b1010_1010, 8);
        check("clamp_hits", 32'(hits), 32'd1);
        configure(8'b1, 1, 1'b0);
        hits = 0;
        repeat (5) step(1'b1, 1'b1);
        check("tp6_hits", 32'(hits), 32'd5);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("tp6_sat", 32'(match_cnt), 32'd3);
`else
        check("tp6_tied", 32'(match_cnt), 32'd0);
`endif
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("tp6_clr", 32'(match_cnt), 32'd0);
        check("tp6_clr_det", 32'(det), 32'd1);

        // Randomized traffic with occasional reconfiguration, clears and resets.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 30) begin
                int l;
                l = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(0, 15);
                configure(8'($urandom), l, 1'($urandom_range(0, 1)));
            end else if (r < 38) begin
                do_reset();
            end else begin
                cnt_clr = ($urandom_range(0, 99) < 4);
                step(($urandom_range(0, 99) < 80), 1'($urandom_range(0, 1)));
                cnt_clr = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Parametrised, run-time programmable serial bit-pattern detector for patterns of 1 to MAX_LEN bits.
- Generalises the fixed-pattern Moore detector. Adds a programmable pattern and length, a selectable overlap mode, a data qualifier and an optional match counter.
- Sits on a serial input stream and feeds a one-cycle registered detect pulse to downstream control logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- RST_PATTERN, 8'b0000_1011, pattern loaded at reset (MAX_LEN bits wide).
- RST_LEN, 4, pattern length loaded at reset.
- RST_OVERLAP, 1, overlap mode loaded at reset.
- CNT_W, 16, match counter width (used only with the optional feature).
- Derived localparam: LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- data_valid  in  1  qualifies data_in this cycle.
- data_in  in  1  serial data bit.
- cfg_we  in  1  load the cfg_* fields into the internal config registers.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- det  out  1  registered detect pulse.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst=0):
  - pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP.
  - history=0, fill=0, det=0, match_cnt=0.
  - Reset mid-stream discards the partial match and all history.
- State:
  - history, MAX_LEN-bit shift register.
  - fill, 0..MAX_LEN saturating count of valid bits held since the last clear.
- Accepted bit: a cycle with data_valid=1 and cfg_we=0.
  - history <= {history[MAX_LEN-2:0], data_in}.
  - fill <= min(fill+1, MAX_LEN).
- Match condition, combinational, on an accepted bit:
  - (fill+1) >= len and len != 0;
  - the low len bits of {history, data_in} equal the low len bits of pattern.
- det:
  - det <= match. det is high for exactly one clk cycle following the edge that sampled the completing bit (Moore: register output only).
  - Back-to-back matches produce back-to-back det cycles.
- Overlap:
  - overlap=1: history and fill continue unaffected after a match. With pattern 1011, stream 1011011 matches twice.
  - overlap=0: on a match, fill <= 0 and history <= 0, so the next match needs len fresh bits.
- data_valid=0: history and fill hold; det <= 0.
- Configuration (cfg_we=1):
  - Loads pattern, len and overlap.
  - Clears history, fill and det the next cycle.
  - data_in is discarded that cycle (cfg wins over data).
  - match_cnt is not affected.
- Length boundaries:
  - cfg_len=0: detector disabled; det is never asserted.
  - cfg_len > MAX_LEN: clamped to MAX_LEN at load.
  - cfg_len=1: every accepted bit equal to pattern[0] produces det.
  - In overlap=0 with len=1, every equal bit also matches.
- Pattern bits above len-1 are ignored.
- Latency: exactly 1 clk from the completing accepted bit to det.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments by 1 on each match and saturates at 2^CNT_W-1.
  - cnt_clr=1 sets match_cnt to 0 next cycle. cnt_clr has priority over a simultaneous match: result is 0, that match is not counted.
- Undefined:
  - No counter register; match_cnt is tied to 0 and cnt_clr is ignored.
  - det behaviour is identical in both builds.

Test Plan:
- Reset defaults (1011, len 4, overlap=1); stream 1,0,1,1,0,1,1 with data_valid=1 -> det high in the cycles after bits 4 and 7 only; match_cnt=2 (feature on).
- cfg_we with pattern 1011, len 4, overlap=0; same stream 1011011 -> single det after bit 4; no det after bit 7.
- cfg_we with pattern 6'b110011, len 6; stream 0,1,1,0,0,1,1 -> det only after bit 7. Then load cfg_len=0 and repeat -> no det.
- Default config; stream 1,0,1,1 with data_valid=0 bubbles inserted between bits 2 and 3 -> det after the 4th valid bit; det low during bubbles.
- Stream 1,0,1; assert rst for 1 cycle; then 1 -> no det. Then 0,1,1 -> det.
- SEQ_DET_MATCH_CNT_EN, CNT_W=2: 5 overlapping matches of pattern 1 (len 1) -> match_cnt=3 (saturated). Then cnt_clr together with a match -> match_cnt=0.
